// File: rtl/tap_lfsr_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : tap_lfsr_stream_if
// Purpose  : Byte stream handshake bundle between tap_lfsr_stream (master)
//            and its downstream consumer (slave).
// Signals  : dout        8   generated byte
//            dout_valid  1   dout holds a completed byte
//            dout_ready  1   consumer accepts dout when valid && ready
// Revision : 1.0 - initial release
// ============================================================================
interface tap_lfsr_stream_if;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;

  modport master (output dout, output dout_valid, input dout_ready);
  modport slave  (input dout, input dout_valid, output dout_ready);
endinterface
`default_nettype wire

// File: rtl/tap_lfsr_stream.sv
`default_nettype none
// ============================================================================
// Module   : tap_lfsr_stream
// Purpose  : Latches a packed tap list, walks it one slot per enabled cycle
//            to build a Fibonacci feedback mask, then runs the LFSR and
//            streams pseudo-random bytes (first generated bit = MSB).
// Ports    : clk           system clock, rising edge
//            res           asynchronous active-high reset
//            taps_i        packed tap list, slot i at [(i+1)*8-1 -: 8]
//            taps_valid_i  tap list complete; sampled only in IDLE
//            ena_i         advance enable for LOAD and RUN
//            loaded_o      high while in RUN
//            err_o         degenerate tap list, sticky until res
//            strm          byte stream handshake (master side)
// Revision : 1.0 - initial release
// ============================================================================
module tap_lfsr_stream #(
  parameter int unsigned     NUM_OF_TAPS = 15,
  parameter int unsigned     SIZE        = 32,
  parameter logic [SIZE-1:0] SEED        = {{(SIZE-1){1'b0}}, 1'b1}
) (
  input  wire logic                     clk,
  input  wire logic                     res,
  input  wire logic [NUM_OF_TAPS*8-1:0] taps_i,
  input  wire logic                     taps_valid_i,
  input  wire logic                     ena_i,
  output logic                          loaded_o,
  output logic                          err_o,
  tap_lfsr_stream_if.master             strm
);

  localparam int unsigned IDX_W = (NUM_OF_TAPS > 1) ? $clog2(NUM_OF_TAPS) : 1;

  localparam logic [SIZE-1:0] ONE       = {{(SIZE-1){1'b0}}, 1'b1};
  localparam logic [SIZE-1:0] TOP_BIT   = ONE << (SIZE - 1);
  localparam logic [SIZE-1:0] SEED_INIT = (SEED == '0) ? ONE : SEED;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]               state_q,    state_d;
  logic [NUM_OF_TAPS*8-1:0] captured_q, captured_d;
  logic [SIZE-1:0]          mask_q,     mask_d;
  logic [IDX_W-1:0]         idx_q,      idx_d;
  logic                     any_low_q,  any_low_d;   // some accepted tap below the top bit
  logic [SIZE-1:0]          lfsr_q,     lfsr_d;
  logic [6:0]               shreg_q,    shreg_d;     // bits of the byte in progress
  logic [2:0]               bitcnt_q,   bitcnt_d;
  logic [7:0]               dout_q,     dout_d;
  logic                     dout_valid_q, dout_valid_d;
  logic                     err_q,      err_d;

  logic [7:0]      slot;
  logic [SIZE-1:0] mask_set;
  logic            slot_low;
  logic            fb;
  logic            accept;
  logic            stall;

  always_comb begin
    // Current slot byte and its contribution to the mask. Out-of-range and
    // zero slots match no bit position and are therefore ignored.
    slot     = '0;
    mask_set = mask_q;
    slot_low = 1'b0;
    for (int i = 0; i < int'(NUM_OF_TAPS); i++) begin
      if (idx_q == IDX_W'(i)) begin
        slot = captured_q[i*8 +: 8];
      end
    end
    for (int b = 0; b < int'(SIZE); b++) begin
      if (slot == 8'(b + 1)) begin
        mask_set[b] = 1'b1;
        if (b < int'(SIZE) - 1) begin
          slot_low = 1'b1;
        end
      end
    end

    fb     = ^(lfsr_q & mask_q);
    accept = dout_valid_q & strm.dout_ready;
    stall  = dout_valid_q & ~strm.dout_ready;

    state_d      = state_q;
    captured_d   = captured_q;
    mask_d       = mask_q;
    idx_d        = idx_q;
    any_low_d    = any_low_q;
    lfsr_d       = lfsr_q;
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    err_d        = err_q;

    // The handshake completes regardless of ena; a byte completing in the
    // same cycle overrides this below.
    if (accept) begin
      dout_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (taps_valid_i) begin
          captured_d = taps_i;
          mask_d     = '0;
          idx_d      = '0;
          any_low_d  = 1'b0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (ena_i) begin
          any_low_d = any_low_q | slot_low;
          if (idx_q == IDX_W'(NUM_OF_TAPS - 1)) begin
            // Forcing the top bit keeps the shift map invertible.
            mask_d = mask_set | TOP_BIT;
            if (any_low_q | slot_low) begin
              state_d = S_RUN;
            end else begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end
          end else begin
            mask_d = mask_set;
            idx_d  = idx_q + IDX_W'(1);
          end
        end
      end
      S_RUN: begin
        if (ena_i && !stall) begin
          lfsr_d  = {lfsr_q[SIZE-2:0], fb};
          shreg_d = {shreg_q[5:0], fb};
          if (bitcnt_q == 3'd7) begin
            dout_d       = {shreg_q, fb};
            dout_valid_d = 1'b1;
            bitcnt_d     = 3'd0;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
      end
      default: begin
        dout_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q      <= S_IDLE;
      captured_q   <= '0;
      mask_q       <= '0;
      idx_q        <= '0;
      any_low_q    <= 1'b0;
      lfsr_q       <= SEED_INIT;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      captured_q   <= captured_d;
      mask_q       <= mask_d;
      idx_q        <= idx_d;
      any_low_q    <= any_low_d;
      lfsr_q       <= lfsr_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      err_q        <= err_d;
    end
  end

  assign strm.dout       = dout_q;
  assign strm.dout_valid = dout_valid_q;
  assign loaded_o        = (state_q == S_RUN);
  assign err_o           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_tap_lfsr_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_tap_lfsr_stream
// Purpose  : Self-checking bench for tap_lfsr_stream. Two instances
//            (SIZE=4/2 slots and SIZE=32/15 slots) share stimulus; a select
//            chooses which one is observed. Expected bytes come from an
//            arithmetic LFSR model built from the tap list.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tap_lfsr_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         res = 1'b0;
  logic [119:0] taps_s = '0;
  logic         tv = 1'b0;
  logic         ena = 1'b0;
  logic         rdy = 1'b0;
  logic         sel = 1'b0;
  logic         loaded_a, err_a, loaded_b, err_b;

  tap_lfsr_stream_if ifa();
  tap_lfsr_stream_if ifb();
  assign ifa.dout_ready = rdy;
  assign ifb.dout_ready = rdy;

  tap_lfsr_stream #(.NUM_OF_TAPS(2), .SIZE(4)) u_dut_a (
    .clk(clk), .res(res), .taps_i(taps_s[15:0]), .taps_valid_i(tv), .ena_i(ena),
    .loaded_o(loaded_a), .err_o(err_a), .strm(ifa)
  );

  tap_lfsr_stream #(.NUM_OF_TAPS(15), .SIZE(32)) u_dut_b (
    .clk(clk), .res(res), .taps_i(taps_s), .taps_valid_i(tv), .ena_i(ena),
    .loaded_o(loaded_b), .err_o(err_b), .strm(ifb)
  );

  logic [7:0] dout_m;
  logic       valid_m, loaded_m, err_m;
  assign dout_m   = sel ? ifb.dout       : ifa.dout;
  assign valid_m  = sel ? ifb.dout_valid : ifa.dout_valid;
  assign loaded_m = sel ? loaded_b       : loaded_a;
  assign err_m    = sel ? err_b          : err_a;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Mask from the tap list, then the bit stream packed MSB-first into bytes.
  // Returns 1 when the list is degenerate (no tap below the top position).
  function automatic bit build_expect(input int size, input int ntaps,
                                      input logic [119:0] tl, input int nbytes);
    longint unsigned mask, st, lim;
    bit              good, fb;
    int              t;
    logic [7:0]      b;
    mask = 0;
    st   = 1;
    good = 1'b0;
    exp_q.delete();
    for (int i = 0; i < ntaps; i++) begin
      t = int'(tl[i*8 +: 8]);
      if (t >= 1 && t <= size) begin
        mask |= 64'd1 << (t - 1);
        if (t < size) good = 1'b1;
      end
    end
    mask |= 64'd1 << (size - 1);
    lim = (64'd1 << size) - 64'd1;
    for (int n = 0; n < nbytes; n++) begin
      b = '0;
      for (int j = 0; j < 8; j++) begin
        fb = ^(st & mask);
        st = ((st << 1) | 64'(fb)) & lim;
        b  = {b[6:0], fb};
      end
      exp_q.push_back(b);
    end
    return !good;
  endfunction

  task automatic run(input bit s, input logic [119:0] tl, input int ena_pct,
                     input int rdy_pct, input int nbytes, input int stall_len,
                     input bit strict);
    int num, size, en_cnt, k, cyc, stall_left;
    bit bad, seen_l, seen_e, seen_v, prev_v, acc_prev, in_stall;
    num  = s ? 15 : 2;
    size = s ? 32 : 4;
    bad  = build_expect(size, num, tl, nbytes);
    sel  = s;
    // Reset lands between clock edges; outputs must clear without a clock.
    #2 res = 1'b1;
    #1 check_value("reset_outputs", {loaded_m, err_m, valid_m, dout_m}, '0);
    tv = 1'b0; ena = 1'b0; rdy = 1'b0; taps_s = tl;
    @(negedge clk);
    @(negedge clk);
    res = 1'b0;
    tv = 1'b1; ena = 1'b1;
    @(negedge clk);
    tv = 1'b0;
    taps_s = ~tl;  // must be ignored once captured
    en_cnt = 0; k = 0; cyc = 0; stall_left = stall_len;
    seen_l = 0; seen_e = 0; seen_v = 0; prev_v = 0; acc_prev = 0; in_stall = 0;
    while (k < nbytes && cyc < 1500) begin
      cyc++;
      if (bad && cyc > num + 20) break;
      if (loaded_m && !seen_l) begin
        check_value("load_time", 64'(en_cnt), 64'(num));
        seen_l = 1;
      end
      if (err_m && !seen_e) begin
        check_value("err_time", 64'(en_cnt), 64'(num));
        seen_e = 1;
      end
      if (in_stall)
        check_value("stall_hold", {valid_m, dout_m}, {1'b1, exp_q[k]});
      if (valid_m && (!prev_v || acc_prev) && (k == 0 || strict))
        check_value("byte_time", 64'(en_cnt), 64'(num + 8 * (k + 1)));
      if (valid_m) seen_v = 1;
      prev_v = valid_m;
      // Drive inputs for the next rising edge.
      ena = ($urandom_range(0, 99) < ena_pct);
      if (ena) en_cnt++;
      in_stall = seen_v && (stall_left > 0);
      if (in_stall) begin
        rdy = 1'b0;
        stall_left--;
      end else begin
        rdy = ($urandom_range(0, 99) < rdy_pct);
      end
      acc_prev = valid_m && rdy;
      if (acc_prev) begin
        check_value("byte", 64'(dout_m), 64'(exp_q[k]));
        if (!s && tl[15:0] == 16'h0003 && k == 0)
          check_value("byte1_literal", 64'(dout_m), 64'h35);
        k++;
      end
      @(negedge clk);
    end
    check_value("loaded_seen", 64'(seen_l), 64'(!bad));
    check_value("err_seen",    64'(seen_e), 64'(bad));
    check_value("valid_seen",  64'(seen_v), 64'(!bad));
    check_value("bytes_taken", 64'(k),      bad ? 64'd0 : 64'(nbytes));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [119:0] tl;
    logic [7:0]   pool [5];
    pool[0] = 8'd0; pool[1] = 8'd40; pool[2] = 8'd32; pool[3] = 8'd33; pool[4] = 8'd200;

    @(negedge clk);
    // x^4+x^3+1, full rate, checks first-byte literal and back-to-back timing
    run(1'b0, 120'h0003, 100, 100, 4, 0, 1'b1);
    // backpressure: 20 cycles of ready low after the first byte
    run(1'b0, 120'h0003, 100, 100, 3, 20, 1'b0);
    // stop partway through byte 3; the next run resets mid-RUN
    run(1'b0, 120'h0003, 100, 100, 2, 0, 1'b1);
    repeat (4) @(negedge clk);
    // ena gating must not change the byte sequence
    run(1'b0, 120'h0003, 50, 100, 4, 0, 1'b0);
    run(1'b0, 120'h0003, 50, 40, 4, 0, 1'b0);
    // random small tap lists, some degenerate
    for (int r = 0; r < 8; r++) begin
      tl = '0;
      tl[7:0]  = 8'($urandom_range(0, 6));
      tl[15:8] = 8'($urandom_range(0, 6));
      run(1'b0, tl, ($urandom_range(0, 1) != 0) ? 50 : 100,
          30 + int'($urandom_range(0, 70)), 5, 0, 1'b0);
    end
    // SIZE=32 degenerate list: only 0, 32 or out-of-range slots
    tl = '0;
    for (int i = 0; i < 15; i++) tl[i*8 +: 8] = pool[$urandom_range(0, 4)];
    run(1'b1, tl, 100, 100, 4, 0, 1'b0);
    // SIZE=32 x^32+x^22+x^2+x+1 with junk slots around the real taps
    tl = '0;
    for (int i = 0; i < 15; i++) tl[i*8 +: 8] = pool[$urandom_range(0, 4)];
    tl[7:0] = 8'd32; tl[31:24] = 8'd22; tl[63:56] = 8'd2; tl[79:72] = 8'd1;
    run(1'b1, tl, 100, 70, 6, 0, 1'b0);
    run(1'b1, tl, 100, 100, 4, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tap_lfsr_stream.md
Name: tap_lfsr_stream

Overview:
- Consumer of the packed tap vector produced by the tap selector.
- Latches the tap list, walks it one byte per cycle, and builds a SIZE-bit Fibonacci feedback mask.
- Then runs the LFSR and streams pseudo-random bytes out over a valid/ready handshake.
- Sits directly downstream of the selector; its taps_valid input is driven by the selector's done.

Parameters:
NUM_OF_TAPS, 15, number of 8-bit tap slots in the packed taps input
SIZE, 32, LFSR state width in bits (legal range 4..255)
SEED, 1, initial LFSR state; a value of 0 is replaced by 1

Ports:
clk  input  1  system clock, rising edge
res  input  1  asynchronous active-high reset
taps  input  NUM_OF_TAPS*8  packed tap list; slot i occupies bits [(i+1)*8-1 -: 8]; value 0 means empty slot
taps_valid  input  1  tap list stable and complete; sampled only in IDLE
ena  input  1  advance enable for LOAD and RUN; when low, all state holds
dout  output  8  generated byte
dout_valid  output  1  dout holds a completed byte
dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready
loaded  output  1  high while in RUN
err  output  1  degenerate tap list detected; sticky until res

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE, lfsr = SEED (or 1), mask = 0, idx = 0, bitcnt = 0, shreg = 0.
  - dout = 0, dout_valid = 0, loaded = 0, err = 0.
- IDLE:
  - taps_valid = 1 at a clock edge: capture taps into an internal register, clear mask, set idx = 0, go to LOAD.
  - Later changes on the taps input are ignored until the next reset.
- LOAD (one slot per ena cycle):
  - Slot byte t = captured[(idx+1)*8-1 -: 8].
  - If 1 <= t <= SIZE, set mask bit t-1; otherwise ignore the slot (0 and out-of-range values alike).
  - idx increments. After slot NUM_OF_TAPS-1, force mask bit SIZE-1.
  - If no accepted slot set a bit other than SIZE-1, go to ERR; else go to RUN.
  - LOAD lasts exactly NUM_OF_TAPS enabled cycles.
  - Duplicate tap values are harmless because bits are set, never toggled.
- RUN, one shift per cycle when ena = 1 and not stalled:
  - fb = XOR-reduce(lfsr & mask).
  - lfsr <= {lfsr[SIZE-2:0], fb}.
  - shreg <= {shreg[6:0], fb}, so the first generated bit becomes the MSB of the byte.
  - bitcnt increments.
- Byte output:
  - When the 8th bit is shifted: dout <= {shreg[6:0], fb}, dout_valid <= 1, bitcnt <= 0.
  - First byte appears 8 enabled RUN cycles after entering RUN.
- Stall: while dout_valid = 1 and dout_ready = 0, the LFSR and bitcnt freeze and dout is held stable.
- Same-cycle accept and complete:
  - If dout_valid && dout_ready in the cycle the next byte would complete, the new byte replaces dout and dout_valid stays 1.
  - If the accept occurs with no byte completing, dout_valid drops to 0.
  - Sustained throughput is 1 byte per 8 enabled cycles, with no bubble when ready is held high.
- ena = 0: no shift, no idx advance; the handshake still completes (dout_valid clears on ready).
- ERR: err = 1, loaded = 0, dout_valid = 0; terminal until res.
- RUN is terminal until res; taps_valid is ignored outside IDLE.
- An all-zero LFSR state is unreachable, because the seed is nonzero and the forced top bit keeps the map invertible.

Test Plan:
- SIZE=4, NUM_OF_TAPS=2, SEED=1, taps={8'd0,8'd3}, taps_valid pulse, ena=1, dout_ready=1 -> mask=4'b1100; loaded rises after 2 LOAD cycles; first byte dout=8'h35 exactly 8 cycles later.
- Same config, continuous run -> fb bit stream has period 15; bytes 2 and 3 match a reference model of x^4+x^3+1; dout_valid is never low between bytes.
- Backpressure: hold dout_ready=0 for 20 cycles after the first byte -> dout stays 8'h35, LFSR frozen; after release, the next byte equals the byte produced without the stall.
- Degenerate list: SIZE=32, all slots 0 or values >32 (e.g. 8'd40) -> after NUM_OF_TAPS cycles err=1, loaded=0, no dout_valid ever.
- Async reset mid-RUN: assert res between clock edges partway through byte 3 -> dout_valid, loaded, err and dout drop immediately; a fresh taps_valid reproduces byte 1 = 8'h35 from the first scenario.
- ena gating: toggle ena 50% during LOAD and RUN -> LOAD takes NUM_OF_TAPS enabled cycles and the byte sequence is identical to the ena=1 case.
